// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch PC unit.
// Optional counters live in pc_fetch_ctrl under PC_PERF_EN.
package pc_pkg;

  typedef enum logic {
    PC_REQ  = 1'b0,
    PC_HOLD = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER_VEC = 32'h0000_4180;
  localparam logic [31:0] PC_TEXT_LO     = 32'h0000_3000;
  localparam logic [31:0] PC_TEXT_HI     = 32'h0000_6ffc;

endpackage

// File: rtl/pc_redirect_buf.sv
// Buffers one redirect seen while a fetch is outstanding and
// resolves the redirect target (IntReq > ERET > pending).
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] HANDLER_VEC = ADDR_W'(PC_HANDLER_VEC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              clr,
  input  logic              IntReq,
  input  logic              ERET,
  input  logic [ADDR_W-1:0] EPC,
  output logic              PendValid,
  output logic [ADDR_W-1:0] target
);

  logic              pend_int;
  logic [ADDR_W-1:0] pend_pc;

  // an ERET may replace an older ERET, never an older IntReq
  always_ff @(posedge clk) begin
    if (reset) begin
      PendValid <= 1'b0;
      pend_int  <= 1'b0;
      pend_pc   <= '0;
    end else if (wr) begin
      if (IntReq) begin
        PendValid <= 1'b1;
        pend_int  <= 1'b1;
        pend_pc   <= HANDLER_VEC;
      end else if (!(PendValid && pend_int)) begin
        PendValid <= 1'b1;
        pend_int  <= 1'b0;
        pend_pc   <= EPC;
      end
    end else if (clr) begin
      PendValid <= 1'b0;
      pend_int  <= 1'b0;
    end
  end

  always_comb begin
    target = pend_pc;
    unique case (1'b1)
      IntReq:  target = HANDLER_VEC;
      ERET:    target = EPC;
      default: target = pend_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC with req/ack handshake, redirect buffering and range check.
// Define PC_PERF_EN to add FetchCnt/KillCnt/WaitCnt counters.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(PC_RESET_VEC),
  parameter logic [ADDR_W-1:0] HANDLER_VEC = ADDR_W'(PC_HANDLER_VEC),
  parameter logic [ADDR_W-1:0] TEXT_LO     = ADDR_W'(PC_TEXT_LO),
  parameter logic [ADDR_W-1:0] TEXT_HI     = ADDR_W'(PC_TEXT_HI),
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              IntReq,
  input  logic              ERET,
  input  logic [ADDR_W-1:0] PCI,
  input  logic [ADDR_W-1:0] EPC,
  input  logic              FetchAck,
  output logic [ADDR_W-1:0] PCO,
  output logic              FetchReq,
  output logic              InstrValid,
  output logic              Err
`ifdef PC_PERF_EN
  ,
  output logic [31:0]       FetchCnt,
  output logic [31:0]       KillCnt,
  output logic [31:0]       WaitCnt
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_state_e         state;
  logic              in_req;
  logic              done;
  logic              ext_redir;
  logic              redir;
  logic              pend_valid;
  logic              pend_wr;
  logic              pend_clr;
  logic [ADDR_W-1:0] target;

  assign Err = ((PCO & ALIGN_MASK) != '0)
             || (PCO < TEXT_LO)
             || (PCO > TEXT_HI);

  assign in_req    = (state == PC_REQ);
  assign ext_redir = IntReq | ERET;
  assign redir     = ext_redir | pend_valid;
  // a faulting PC completes at once without touching memory
  assign done      = in_req & (FetchAck | Err);
  assign FetchReq  = in_req & ~Err;
  assign pend_wr   = in_req & ~done & ext_redir;
  assign pend_clr  = done & redir;

  always_comb begin
    InstrValid = 1'b0;
    unique case (1'b1)
      in_req:  InstrValid = done & ~redir;
      default: InstrValid = ~ext_redir;
    endcase
  end

  pc_redirect_buf #(
    .ADDR_W      (ADDR_W),
    .HANDLER_VEC (HANDLER_VEC)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr        (pend_wr),
    .clr       (pend_clr),
    .IntReq    (IntReq),
    .ERET      (ERET),
    .EPC       (EPC),
    .PendValid (pend_valid),
    .target    (target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PC_REQ;
      PCO   <= RESET_VEC;
    end else begin
      case (state)
        PC_REQ: begin
          if (done) begin
            if (redir) begin
              PCO <= target;
            end else if (Stall) begin
              state <= PC_HOLD;
            end else begin
              PCO <= PCI;
            end
          end
        end
        PC_HOLD: begin
          if (ext_redir) begin
            PCO   <= target;
            state <= PC_REQ;
          end else if (!Stall) begin
            PCO   <= PCI;
            state <= PC_REQ;
          end
        end
        default: begin
          state <= PC_REQ;
        end
      endcase
    end
  end

`ifdef PC_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      FetchCnt <= '0;
      KillCnt  <= '0;
      WaitCnt  <= '0;
    end else begin
      if (done && !redir) FetchCnt <= FetchCnt + 32'd1;
      if (done && redir)  KillCnt  <= KillCnt + 32'd1;
      if (FetchReq && !FetchAck) WaitCnt <= WaitCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with hand-computed vectors.
// Also checks the PC_PERF_EN counters when that macro is defined.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        IntReq;
  logic        ERET;
  logic [31:0] PCI;
  logic [31:0] EPC;
  logic        FetchAck;
  logic [31:0] PCO;
  logic        FetchReq;
  logic        InstrValid;
  logic        Err;
`ifdef PC_PERF_EN
  logic [31:0] FetchCnt;
  logic [31:0] KillCnt;
  logic [31:0] WaitCnt;
`endif

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .IntReq     (IntReq),
    .ERET       (ERET),
    .PCI        (PCI),
    .EPC        (EPC),
    .FetchAck   (FetchAck),
    .PCO        (PCO),
    .FetchReq   (FetchReq),
    .InstrValid (InstrValid),
    .Err        (Err)
`ifdef PC_PERF_EN
    ,
    .FetchCnt   (FetchCnt),
    .KillCnt    (KillCnt),
    .WaitCnt    (WaitCnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Stall = 0; IntReq = 0; ERET = 0; FetchAck = 0;
  endtask

  // one acked fetch moving PCO to pc
  task automatic go(input logic [31:0] pc);
    idle();
    FetchAck = 1; PCI = pc;
    tick();
    idle();
  endtask

  initial begin
    reset = 1; PCI = 0; EPC = 0;
    idle();
    tick();
    tick();
    reset = 0;
    settle();
    chk("rst_pco", PCO, 32'h3000);
    chk("rst_req", {31'd0, FetchReq}, 32'd1);
    chk("rst_iv", {31'd0, InstrValid}, 32'd0);
    chk("rst_err", {31'd0, Err}, 32'd0);

    // 1: back-to-back acks
    for (int i = 0; i < 4; i++) begin
      FetchAck = 1; PCI = 32'h3000 + 32'(i + 1) * 4;
      settle();
      chk("seq_iv", {31'd0, InstrValid}, 32'd1);
      chk("seq_err", {31'd0, Err}, 32'd0);
      tick();
      chk("seq_pco", PCO, 32'h3000 + 32'(i + 1) * 4);
    end

    // 2: wait states with IntReq in the 2nd cycle
    idle(); PCI = 32'h3014;
    settle();
    chk("w1_req", {31'd0, FetchReq}, 32'd1);
    chk("w1_iv", {31'd0, InstrValid}, 32'd0);
    tick();
    IntReq = 1;
    settle();
    chk("w2_iv", {31'd0, InstrValid}, 32'd0);
    tick();
    IntReq = 0;
    chk("w2_pco", PCO, 32'h3010);
    chk("w2_req", {31'd0, FetchReq}, 32'd1);
    tick();
    chk("w3_pco", PCO, 32'h3010);
    FetchAck = 1;
    settle();
    chk("kill_iv", {31'd0, InstrValid}, 32'd0);
    tick();
    chk("int_pco", PCO, 32'h4180);

    // 3a: pending ERET then IntReq
    go(32'h3050);
    chk("mv_pco", PCO, 32'h3050);
    ERET = 1; EPC = 32'h3020;
    tick();
    ERET = 0; IntReq = 1;
    tick();
    IntReq = 0; FetchAck = 1; PCI = 32'h3054;
    settle();
    chk("er_int_iv", {31'd0, InstrValid}, 32'd0);
    tick();
    chk("er_int_pco", PCO, 32'h4180);

    // 3b: pending IntReq then ERET
    go(32'h3060);
    IntReq = 1;
    tick();
    IntReq = 0; ERET = 1; EPC = 32'h3020;
    tick();
    ERET = 0; FetchAck = 1; PCI = 32'h3064;
    tick();
    chk("int_er_pco", PCO, 32'h4180);

    // 3c: lone pending ERET
    go(32'h3070);
    ERET = 1; EPC = 32'h3020;
    tick();
    ERET = 0; FetchAck = 1; PCI = 32'h3074;
    tick();
    chk("er_pco", PCO, 32'h3020);

    // 4: faulting PCs complete with no request
    go(32'h3002);
    settle();
    chk("mis_err", {31'd0, Err}, 32'd1);
    chk("mis_req", {31'd0, FetchReq}, 32'd0);
    chk("mis_iv", {31'd0, InstrValid}, 32'd1);
    tick();
    chk("mis_pco", PCO, 32'h3002);
    IntReq = 1;
    settle();
    chk("mis_kill", {31'd0, InstrValid}, 32'd0);
    tick();
    IntReq = 0;
    chk("mis_vec", PCO, 32'h4180);
    chk("mis_clr", {31'd0, Err}, 32'd0);

    go(32'h7000);
    settle();
    chk("hi_err", {31'd0, Err}, 32'd1);
    chk("hi_req", {31'd0, FetchReq}, 32'd0);
    chk("hi_iv", {31'd0, InstrValid}, 32'd1);
    IntReq = 1;
    tick();
    IntReq = 0;
    chk("hi_vec", PCO, 32'h4180);

    go(32'h2ffc);
    settle();
    chk("lo_err", {31'd0, Err}, 32'd1);
    chk("lo_iv", {31'd0, InstrValid}, 32'd1);
    IntReq = 1;
    tick();
    IntReq = 0;
    chk("lo_vec", PCO, 32'h4180);

    go(32'h6ffc);
    chk("top_err", {31'd0, Err}, 32'd0);
    go(32'h4180);

    // 5: stall into HOLD
    FetchAck = 1; Stall = 1; PCI = 32'h3030;
    settle();
    chk("st_iv0", {31'd0, InstrValid}, 32'd1);
    tick();
    chk("st_pco0", PCO, 32'h4180);
    settle();
    chk("st_iv1", {31'd0, InstrValid}, 32'd1);
    chk("st_req1", {31'd0, FetchReq}, 32'd0);
    tick();
    chk("st_pco1", PCO, 32'h4180);
    FetchAck = 0; Stall = 0; PCI = 32'h3040;
    settle();
    chk("st_iv2", {31'd0, InstrValid}, 32'd1);
    tick();
    chk("st_rel", PCO, 32'h3040);
    FetchAck = 1; Stall = 1; PCI = 32'h3044;
    tick();
    FetchAck = 0; ERET = 1; EPC = 32'h3100;
    settle();
    chk("hold_er_iv", {31'd0, InstrValid}, 32'd0);
    tick();
    idle();
    chk("hold_er_pco", PCO, 32'h3100);
    chk("hold_er_req", {31'd0, FetchReq}, 32'd1);

    // 6: reset mid-fetch with a pending IntReq and late ack
    IntReq = 1;
    tick();
    IntReq = 0;
    tick();
    reset = 1; FetchAck = 1; PCI = 32'h3abc;
    tick();
    reset = 0; FetchAck = 0;
    settle();
    chk("r6_pco", PCO, 32'h3000);
    chk("r6_req", {31'd0, FetchReq}, 32'd1);
    chk("r6_iv", {31'd0, InstrValid}, 32'd0);
`ifdef PC_PERF_EN
    chk("r6_fcnt", FetchCnt, 32'd0);
    chk("r6_kcnt", KillCnt, 32'd0);
    chk("r6_wcnt", WaitCnt, 32'd0);
`endif
    FetchAck = 1; PCI = 32'h3004;
    settle();
    chk("r6_nopend", {31'd0, InstrValid}, 32'd1);
    tick();
    chk("r6_next", PCO, 32'h3004);
`ifdef PC_PERF_EN
    chk("r6_fcnt1", FetchCnt, 32'd1);
    chk("r6_kcnt1", KillCnt, 32'd0);
`endif
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
